// File: rtl/sum_reducer_pkg.sv
// Shared encodings and default widths for the pass sum reducer.
// Imported by the reducer, its max tracker and neighbouring blocks.
package sum_reducer_pkg;

    localparam int DEF_IDX_W  = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_reducer_max_tracker.sv
// Running unsigned maximum and the index of its first occurrence.
// Strict greater-than keeps the earliest index on ties.
module max_tracker
    import sum_reducer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_first,
    input  logic [DATA_W-1:0] i_value,
    input  logic [IDX_W-1:0]  i_index,
    output logic [DATA_W-1:0] o_max,
    output logic [IDX_W-1:0]  o_max_index
);

    logic [DATA_W-1:0] r_max;
    logic [IDX_W-1:0]  r_max_index;
    logic              w_take;

    assign w_take = i_load && (i_first || (i_value > r_max));

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_max       <= '0;
            r_max_index <= '0;
        end else if (w_take) begin
            r_max       <= i_value;
            r_max_index <= i_index;
        end
    end

    assign o_max       = r_max;
    assign o_max_index = r_max_index;

endmodule

// File: rtl/sum_reducer.sv
// Reduces one pass of 2**IDX_W (index, sum) beats to total, max, argmax
// and sticky overflow / sequence flags, then holds the result for handoff.
module sum_reducer
    import sum_reducer_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_total,
    output logic [DATA_W-1:0] res_max,
    output logic [IDX_W-1:0]  res_max_index,
    output logic              res_ovf,
    output logic              res_seq_err,
    output logic [15:0]       pass_count
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << IDX_W) - 1);

    state_t             r_state;
    logic [ACC_W-1:0]   r_total;
    logic               r_ovf;
    logic               r_seq_err;
    logic [IDX_W-1:0]   r_exp_index;
    logic [CNT_W-1:0]   r_beats;
    logic [15:0]        r_pass_count;

    logic               w_accept;
    logic               w_handoff;
    logic               w_last;
    logic               w_first;
    logic [ACC_W:0]     w_sum;

    // in_ready depends on state only, never on res_ready
    assign in_ready  = (r_state != ST_HOLD);
    assign res_valid = (r_state == ST_HOLD);

    assign w_accept  = in_valid && in_ready;
    assign w_handoff = res_valid && res_ready;
    assign w_last    = (r_beats == LAST);
    assign w_first   = (r_state == ST_IDLE);
    assign w_sum     = {1'b0, r_total}
                     + {{(ACC_W + 1 - DATA_W){1'b0}}, in_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_total      <= '0;
            r_ovf        <= 1'b0;
            r_seq_err    <= 1'b0;
            r_exp_index  <= '0;
            r_beats      <= '0;
            r_pass_count <= '0;
        end else if (w_handoff) begin
            r_state      <= ST_IDLE;
            r_total      <= '0;
            r_ovf        <= 1'b0;
            r_seq_err    <= 1'b0;
            r_exp_index  <= '0;
            r_beats      <= '0;
            r_pass_count <= r_pass_count + 16'd1;
        end else if (w_accept) begin
            r_total     <= w_sum[ACC_W-1:0];
            r_ovf       <= r_ovf | w_sum[ACC_W];
            r_seq_err   <= r_seq_err | (in_index != r_exp_index);
            r_exp_index <= r_exp_index + IDX_W'(1);
            r_beats     <= r_beats + CNT_W'(1);
            r_state     <= w_last ? ST_HOLD : ST_ACCUM;
        end
    end

    max_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max (
        .clk         (clk),
        .i_clr       (rst || w_handoff),
        .i_load      (w_accept),
        .i_first     (w_first),
        .i_value     (in_sum),
        .i_index     (in_index),
        .o_max       (res_max),
        .o_max_index (res_max_index)
    );

    assign res_total   = r_total;
    assign res_ovf     = r_ovf;
    assign res_seq_err = r_seq_err;
    assign pass_count  = r_pass_count;

endmodule

// File: doc/sum_reducer.md
SUM_REDUCER -- requirements
Module: sum_reducer

Interface
REQ-001 Parameter IDX_W, default 8, index width; one pass is 2**IDX_W beats.
REQ-002 Parameter DATA_W, default 32, width of each incoming sum word.
REQ-003 Parameter ACC_W, default 40, width of the pass total accumulator.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: an upstream beat (index, sum) is presented.
REQ-007 Port in_ready, output, 1: the block accepts the beat this cycle; upstream gates its run/advance with it.
REQ-008 Port in_index, input, IDX_W: index of the presented beat.
REQ-009 Port in_sum, input, DATA_W: element-wise sum word of the presented beat.
REQ-010 Port res_valid, output, 1: a pass result is held on the res_* ports.
REQ-011 Port res_ready, input, 1: downstream takes the result.
REQ-012 Port res_total, output, ACC_W: wrapping sum of all in_sum values in the pass.
REQ-013 Port res_max, output, DATA_W: largest unsigned in_sum in the pass.
REQ-014 Port res_max_index, output, IDX_W: in_index of the first beat that carried res_max.
REQ-015 Port res_ovf, output, 1: the pass total exceeded 2**ACC_W-1 at least once.
REQ-016 Port res_seq_err, output, 1: at least one beat in the pass had in_index != expected index.
REQ-017 Port pass_count, output, 16: number of results handed off since reset, wrapping at 65535.

Function
REQ-018 A beat is accepted when in_valid && in_ready; no other state changes from input data.
REQ-019 The block has states IDLE (no beat of the current pass yet), ACCUM (pass in progress) and HOLD (result waiting).
REQ-020 Transitions: IDLE->ACCUM on an accepted beat; ACCUM->HOLD on the accepted beat that makes the beat count 2**IDX_W; HOLD->IDLE on res_valid && res_ready; all other cases hold state.
REQ-021 in_ready = 1 in IDLE and ACCUM and 0 in HOLD; it is a registered-state decode with no combinational path from res_ready.
REQ-022 The expected index starts at 0 in IDLE and increments by 1 (mod 2**IDX_W) on every accepted beat; a mismatch sets the sticky seq error for the pass; the pass still ends on the beat count, not on in_index.
REQ-023 The total is zero-extended in_sum added modulo 2**ACC_W; a carry out of bit ACC_W-1 sets the sticky overflow for the pass.
REQ-024 Max update uses strict greater-than, so ties keep the earlier index; the first beat of a pass always loads max and max index.
REQ-025 res_valid rises the cycle after the final beat is accepted (latency 1) and holds with all res_* stable until handshake.
REQ-026 On handshake the accumulators, max, flags and expected index clear, pass_count increments, and in_ready is 1 the next cycle.
REQ-027 res_* values outside HOLD are don't-care for consumers; the design drives them from the working registers.
REQ-028 A single-beat pass (IDX_W=0) goes IDLE->HOLD directly on its one beat.

Reset
REQ-029 While rst is high on a clock edge: state=IDLE; total, max, max index, flags, expected index, beat count and pass_count=0; res_valid=0; in_ready=1 the next cycle.
REQ-030 Reset mid-pass or in HOLD discards the partial or pending result without a handshake and does not increment pass_count.
REQ-031 rst has priority over in_valid and res_ready in the same cycle.

Structure
REQ-032 The state encoding and the default IDX_W/DATA_W/ACC_W values live in a shared package, sum_reducer_pkg, for use by neighbouring blocks and the bench.
REQ-033 The max/argmax tracker is a sub-module, max_tracker, containing the comparator, max register and index register with load/clear inputs; everything else stays flat.
REQ-034 There are no memories, multicycle paths or clock enables other than beat acceptance.

Verification
REQ-035 IDX_W=8, in_sum=1 for indices 0..255, res_ready=1 -> res_valid one cycle after beat 255; total=256, max=1, max_index=0, ovf=0, seq_err=0, pass_count=1.
REQ-036 in_sum=index, with index 10 and index 200 both carrying 0xFFFFFFFF -> max=0xFFFFFFFF, max_index=10.
REQ-037 ACC_W=33, all 256 in_sum=0xFFFFFFFF -> ovf=1 and total = (256*0xFFFFFFFF) mod 2**33.
REQ-038 res_ready=0 for 20 cycles after completion with in_valid held 1 -> in_ready=0, no beats consumed, res_* stable; after res_ready pulses, the next pass starts with total 0.
REQ-039 Beat 5 presented with index 7 -> seq_err=1, pass still completes after 256 beats.
REQ-040 rst asserted at beat 100, then a clean pass -> result matches that pass only and pass_count=1.
